// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared types and constants for the forwarding/hazard unit
// Purpose: register-address width, forward-select encodings and the shadow-stage record.
// Ports: none (package).
package riscv_pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from ID/EX register-file read
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM ALU result

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              reg_write;
    logic              mem_read;
  } stage_info_t;

  // A stage supplies a value for register rs only if it writes a non-x0 rd equal to rs.
  function automatic logic producer_hit(input logic              wr,
                                        input logic [REG_AW-1:0] rd,
                                        input logic [REG_AW-1:0] rs);
    return wr && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_hazard_unit_if.sv
// rtl/forward_hazard_unit_if.sv - ID-stage request / hazard-result bundle
// Purpose: groups ID-stage instruction info and flush (driven by the pipeline) with the
//   forward selects, bypasses, stall and stall counter (driven by the hazard unit).
// Ports (signals): id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush ->
//   unit; fwd_a, fwd_b, id_byp_a, id_byp_b, stall, stall_count -> pipeline.
interface forward_hazard_unit_if #(
  parameter int REG_AW = riscv_pipe_pkg::REG_AW,
  parameter int CNT_W  = 16
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              id_byp_a;
  logic              id_byp_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
    input  fwd_a, fwd_b, id_byp_a, id_byp_b, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
    output fwd_a, fwd_b, id_byp_a, id_byp_b, stall, stall_count
  );

endinterface

// File: rtl/fwd_sel_cmp.sv
// rtl/fwd_sel_cmp.sv - forward-select comparator for one EX operand
// Purpose: picks the EX operand source for one source register from the EX/MEM and
//   MEM/WB shadow stages; the younger EX/MEM producer takes priority.
// Ports: rs_i (operand source register), exmem_i / memwb_i (shadow stage info),
//   sel_o (00 register file, 01 MEM/WB, 10 EX/MEM; 11 never produced).
module fwd_sel_cmp
  import riscv_pipe_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  stage_info_t       exmem_i,
  input  stage_info_t       memwb_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (producer_hit(exmem_i.reg_write, exmem_i.rd, rs_i)) begin
      sel_o = FWD_MEM;
    end else if (producer_hit(memwb_i.reg_write, memwb_i.rd, rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - EX forwarding selects, load-use stall and ID write-back bypass
// Purpose: shadows rd/reg_write/mem_read of in-flight instructions through ID/EX, EX/MEM
//   and MEM/WB, and derives forwarding selects, ID bypass, load-use stall and a saturating
//   stall counter.
// Ports: clk, rst_n (async, active low), hz (slave side of forward_hazard_unit_if).
module forward_hazard_unit
  import riscv_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  forward_hazard_unit_if.slave  hz
);

  stage_info_t      idex_q, idex_d;
  stage_info_t      exmem_q;
  stage_info_t      memwb_q;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             stall_w;
  logic             ld_use_w;

  // Load in ID/EX whose rd is read by the ID instruction; rs2 is compared even when the
  // instruction does not use it, which may cost a harmless extra stall cycle.
  assign ld_use_w = idex_q.mem_read && (idex_q.rd != '0) &&
                    ((idex_q.rd == hz.id_rs1) || (idex_q.rd == hz.id_rs2));

  // A squashed instruction must never stall, so flush overrides.
  assign stall_w = hz.id_valid && ld_use_w && !hz.flush;

  always_comb begin
    idex_d = '0;
    if (!(stall_w || hz.flush)) begin
      idex_d.valid     = hz.id_valid;
      idex_d.rd        = hz.id_rd;
      idex_d.rs1       = hz.id_rs1;
      idex_d.rs2       = hz.id_rs2;
      idex_d.reg_write = hz.id_reg_write;
      idex_d.mem_read  = hz.id_mem_read;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_w && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q        <= '0;
      exmem_q       <= '0;
      memwb_q       <= '0;
      stall_count_q <= '0;
    end else begin
      idex_q        <= idex_d;
      exmem_q       <= idex_q;
      memwb_q       <= exmem_q;
      stall_count_q <= stall_count_d;
    end
  end

  fwd_sel_cmp u_sel_a (
    .rs_i    (idex_q.rs1),
    .exmem_i (exmem_q),
    .memwb_i (memwb_q),
    .sel_o   (hz.fwd_a)
  );

  fwd_sel_cmp u_sel_b (
    .rs_i    (idex_q.rs2),
    .exmem_i (exmem_q),
    .memwb_i (memwb_q),
    .sel_o   (hz.fwd_b)
  );

  // MEM/WB writes the register file in the same cycle ID reads it.
  assign hz.id_byp_a = hz.id_valid && producer_hit(memwb_q.reg_write, memwb_q.rd, hz.id_rs1);
  assign hz.id_byp_b = hz.id_valid && producer_hit(memwb_q.reg_write, memwb_q.rd, hz.id_rs2);

  assign hz.stall       = stall_w;
  assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - self-checking bench for forward_hazard_unit
module tb_forward_hazard_unit;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       wr;
    bit       ld;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  forward_hazard_unit_if #(.REG_AW(5), .CNT_W(CNT_W)) bus ();

  forward_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // In-flight instructions, oldest last: [0] in EX, [1] in MEM, [2] in WB.
  instr_t      inflight[$];
  int unsigned stalls_seen;
  instr_t      cur;
  bit          cur_flush;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(bit v, bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2, bit wr, bit ld);
    instr_t i;
    i.v = v; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.wr = wr; i.ld = ld;
    return i;
  endfunction

  function automatic instr_t bubble();
    return mk(0, 0, 0, 0, 0, 0);
  endfunction

  task automatic model_reset();
    inflight = {bubble(), bubble(), bubble()};
    stalls_seen = 0;
  endtask

  task automatic apply(input instr_t i, input bit fl);
    cur = i;
    cur_flush = fl;
    bus.id_valid     = i.v;
    bus.id_rd        = i.rd;
    bus.id_rs1       = i.rs1;
    bus.id_rs2       = i.rs2;
    bus.id_reg_write = i.wr;
    bus.id_mem_read  = i.ld;
    bus.flush        = fl;
  endtask

  function automatic bit writes(instr_t p, bit [4:0] r);
    return p.wr && p.rd != 0 && p.rd == r;
  endfunction

  // Nearest older in-flight producer of rs wins: MEM stage -> 10, WB stage -> 01.
  function automatic int unsigned exp_sel(bit [4:0] rs);
    for (int k = 1; k <= 2; k++) begin
      if (writes(inflight[k], rs)) return (k == 1) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic bit exp_stall();
    instr_t e = inflight[0];
    return cur.v && e.ld && e.rd != 0 && (e.rd == cur.rs1 || e.rd == cur.rs2) && !cur_flush;
  endfunction

  function automatic int unsigned exp_cnt();
    return (stalls_seen > CMAX) ? CMAX : stalls_seen;
  endfunction

  task automatic chk();
    @(negedge clk);
    check_eq("fwd_a", bus.fwd_a, exp_sel(inflight[0].rs1));
    check_eq("fwd_b", bus.fwd_b, exp_sel(inflight[0].rs2));
    check_eq("id_byp_a", bus.id_byp_a, cur.v && writes(inflight[2], cur.rs1));
    check_eq("id_byp_b", bus.id_byp_b, cur.v && writes(inflight[2], cur.rs2));
    check_eq("stall", bus.stall, exp_stall());
    check_eq("stall_count", bus.stall_count, exp_cnt());
  endtask

  task automatic adv();
    bit s = exp_stall();
    @(posedge clk);
    if (s) stalls_seen++;
    inflight.push_front((s || cur_flush) ? bubble() : cur);
    void'(inflight.pop_back());
    #1;
  endtask

  task automatic step(input instr_t i, input bit fl);
    apply(i, fl);
    chk();
    adv();
  endtask

  initial begin
    instr_t      nop;
    instr_t      lw8;
    instr_t      use8;
    int unsigned c0;
    nop  = mk(1, 0, 0, 0, 0, 0);
    lw8  = mk(1, 8, 1, 2, 1, 1);
    use8 = mk(1, 9, 8, 8, 1, 0);

    // Reset asserted with active ID inputs.
    model_reset();
    apply(mk(1, 5, 5, 5, 1, 1), 0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_fwd_a", bus.fwd_a, 0);
    check_eq("rst_fwd_b", bus.fwd_b, 0);
    check_eq("rst_byp_a", bus.id_byp_a, 0);
    check_eq("rst_byp_b", bus.id_byp_b, 0);
    check_eq("rst_stall", bus.stall, 0);
    check_eq("rst_count", bus.stall_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // add x5 ; add x6,x5,x1
    step(mk(1, 5, 1, 2, 1, 0), 0);
    step(mk(1, 6, 5, 1, 1, 0), 0);
    apply(nop, 0); chk();
    check_eq("b2b_fwd_a", bus.fwd_a, 2);
    check_eq("b2b_fwd_b", bus.fwd_b, 0);
    adv();

    // add x5 ; nop ; sub x7,x2,x5
    step(mk(1, 5, 1, 2, 1, 0), 0);
    step(nop, 0);
    step(mk(1, 7, 2, 5, 1, 0), 0);
    apply(nop, 0); chk();
    check_eq("gap_fwd_b", bus.fwd_b, 1);
    adv();

    // x5 produced twice: the younger one wins.
    step(mk(1, 5, 1, 2, 1, 0), 0);
    step(mk(1, 5, 3, 4, 1, 0), 0);
    step(mk(1, 6, 5, 5, 1, 0), 0);
    apply(nop, 0); chk();
    check_eq("prio_fwd_a", bus.fwd_a, 2);
    adv();

    // lw x8 ; add x9,x8,x8 -> one stall, then MEM/WB forward.
    step(lw8, 0);
    apply(use8, 0); chk();
    check_eq("lu_stall", bus.stall, 1);
    c0 = bus.stall_count;
    adv();
    apply(use8, 0); chk();
    check_eq("lu_stall_once", bus.stall, 0);
    check_eq("lu_count", bus.stall_count, c0 + 1);
    adv();
    apply(nop, 0); chk();
    check_eq("lu_fwd_a", bus.fwd_a, 1);
    check_eq("lu_fwd_b", bus.fwd_b, 1);
    adv();

    // Flush in the hazard cycle suppresses the stall.
    step(lw8, 0);
    apply(use8, 1); chk();
    check_eq("fl_stall", bus.stall, 0);
    c0 = bus.stall_count;
    adv();
    apply(nop, 0); chk();
    check_eq("fl_count", bus.stall_count, c0);
    adv();

    // x0 is never a producer.
    step(mk(1, 0, 1, 2, 1, 1), 0);
    apply(mk(1, 1, 0, 0, 1, 0), 0); chk();
    check_eq("x0_stall", bus.stall, 0);
    adv();
    apply(nop, 0); chk();
    check_eq("x0_fwd_a", bus.fwd_a, 0);
    adv();
    step(nop, 0);
    step(nop, 0);

    // Randomized traffic on a small register set to get frequent collisions.
    for (int n = 0; n < 400; n++) begin
      step(mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0),
           $urandom_range(0, 7) == 0);
    end

    // Reset in the middle of a stall drops it immediately.
    step(lw8, 0);
    apply(use8, 0); chk();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_stall", bus.stall, 0);
    check_eq("rst_mid_count", bus.stall_count, 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    apply(nop, 0);

    // Drive the counter past saturation.
    for (int n = 0; n < (1 << CNT_W) + 3; n++) begin
      step(lw8, 0);
      step(use8, 0);
      step(use8, 0);
    end
    apply(nop, 0); chk();
    check_eq("sat_count", bus.stall_count, CMAX);
    adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
